muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit providing the MULT, MULTU, DIV and DIVU operations, with architectural HI/LO registers, for the pipelined core. It sits beside the EX-stage ALU. While it is busy, the core stalls any instruction that reads HI/LO or issues another mul/div. One radix-2 step is executed per cycle, so latency scales with WIDTH.

## Interface
- WIDTH, 32, operand and HI/LO width; legal values 2..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- abort  in  1  pipeline flush; cancels the operation in flight.
- busy  out  1  operation in progress; core stalls HI/LO readers and new mul/div.
- done  out  1  one-cycle pulse; HI/LO valid and updated.
- dz  out  1  divide-by-zero flag for the last completed divide; valid from done onward.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: WIDTH iteration steps.
  - FIX: sign fix-up and HI/LO write.
- IDLE->RUN on start & !abort. Capture op, sign flags, and |a|, |b|:
  - Magnitudes are used only for signed ops (op[0]=1); unsigned ops take operands as-is.
  - Clear the accumulator and set count=0.
- RUN, multiply: shift-add on LSB of the multiplier. The 2W-bit accumulator is right-shifted each step.
- RUN, divide: restoring division. Shift {rem,quot} left, trial-subtract the divisor, set quotient bit if no borrow.
- RUN->FIX when count == WIDTH-1, after the last step completes.
- FIX->IDLE, and on this edge:
  - Multiply: {hi,lo} = product. Negate the 2W-bit product if signed and the signs differ.
  - Divide: lo = quotient, hi = remainder. If signed, negate the quotient when the signs differ; the remainder takes the sign of the dividend.
  - Assert done for one cycle. dz = (divide && b==0).
- Divide by zero (b==0, any sign): hi = a (original value), lo = all ones. Always run the full latency, with no early exit.
- Signed overflow, DIV MIN/-1: lo = MIN, hi = 0. This is the natural result of the magnitude arithmetic; no special case is needed.
- abort in RUN or FIX: go to IDLE on the next edge. hi, lo and dz are unchanged, and no done is produced.
- abort and start in the same IDLE cycle: abort wins, and the request is dropped.
- start while busy: ignored, with no queueing.
- done does not block: start is accepted in the done cycle (the state is IDLE).
- hi/lo hold their value between operations. They are written only in FIX, and in reset.

## Timing
- Reset (nrst=0 at an edge):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, dz=0; the counter and accumulators are cleared.
  - Reset mid-operation discards it, with no done.
- Latency: start is sampled at edge E0. Iterations run at E1..E(WIDTH). FIX writes HI/LO at E(WIDTH+1).
- done is high for the cycle after E(WIDTH+1), i.e. WIDTH+1 cycles after the start edge. For WIDTH=32 this is 33 edges.
- busy is high from E0 until E(WIDTH+1). It is registered, from state != IDLE, and falls in the same cycle done rises.
- Back-to-back throughput: one operation per WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULTU a=FFFFFFFF b=FFFFFFFF (WIDTH=32) -> hi=FFFFFFFE, lo=00000001. done exactly 33 edges after start; busy high for those 33 cycles; dz=0.
- MULT a=FFFFFFFD (-3) b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1. Then DIV a=FFFFFFF9 (-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00000064 b=0 -> dz=1, hi=00000064, lo=FFFFFFFF after full latency. Then DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0, dz=0.
- Cancellation and dropped start:
  - Prior result hi=1, lo=2. Start DIVU, then assert abort 10 cycles later.
  - Expect: busy drops next edge, no done, hi=1, lo=2 retained.
  - Also: start+abort in the same cycle -> busy stays 0.
- Start pulsed again mid-RUN -> ignored; the result matches the first request. A new start in the done cycle is accepted, with busy high on the next cycle.
- nrst=0 mid-RUN -> next edge hi=lo=0, busy=done=dz=0. Repeat one MULTU at WIDTH=8: a=FF, b=FF -> hi=FE, lo=01, done 9 edges after start.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (MULTU, MULT, DIVU, DIV) with HI/LO registers.
// One shift-add or restoring-divide step per cycle on operand magnitudes, sign fix-up at the end.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               bzero_q, bzero_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a two's-complement value when treated as signed; MIN maps to itself,
    // which read as unsigned is exactly 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic is_signed);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        return (is_signed && (xs < 0)) ? neg_w(x) : x;
    endfunction

    logic             sgn_a, sgn_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_borrow;

    assign sgn_a = op[0] & a[WIDTH-1];
    assign sgn_b = op[0] & b[WIDTH-1];

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    // The partial remainder stays below the divisor, so a set top bit in the shifted value
    // can never borrow; otherwise a wrapped difference signals the borrow.
    assign div_borrow = div_diff[WIDTH] & ~div_shift[WIDTH];

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = RUN;
                    is_div_d  = op[1];
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    bzero_d   = (b == '0);
                    cnt_d     = '0;
                    acc_hi_d  = '0;
                    acc_lo_d  = op[1] ? mag_w(a, op[0]) : mag_w(b, op[0]);
                    opnd_d    = op[1] ? mag_w(b, op[0]) : mag_w(a, op[0]);
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_borrow};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    if (is_div_q) begin
                        lo_d = bzero_q ? '1 : (neg_res_q ? neg_w(acc_lo_q) : acc_lo_q);
                        hi_d = neg_rem_q ? neg_w(acc_hi_q) : acc_hi_q;
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? neg_2w({acc_hi_q, acc_lo_q})
                                                 : {acc_hi_q, acc_lo_q};
                    end
                    dz_d   = is_div_q & bzero_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        abort8;
    logic        busy8;
    logic        done8;
    logic        dz8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(32)) u32 (
        .clk(clk), .nrst(nrst), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) u8 (
        .clk(clk), .nrst(nrst), .start(start8), .op(op8), .a(a8), .b(b8), .abort(abort8),
        .busy(busy8), .done(done8), .dz(dz8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: sign/zero-extend per op, then use the language's own *, / and %.
    function automatic void model(input int w, input logic [1:0] o, input logic [63:0] x,
                                  input logic [63:0] y, output logic [63:0] mh,
                                  output logic [63:0] ml, output logic mdz);
        logic [63:0]         mask;
        longint              sx, sy, q, r;
        logic signed [127:0] px, py, p;
        mask = (64'd1 << w) - 64'd1;
        if (o[0]) begin
            sx = longint'(x << (64 - w)) >>> (64 - w);
            sy = longint'(y << (64 - w)) >>> (64 - w);
        end else begin
            sx = longint'(x & mask);
            sy = longint'(y & mask);
        end
        mdz = 1'b0;
        if (!o[1]) begin
            px = sx;
            py = sy;
            p  = px * py;
            mh = 64'(p >> w) & mask;
            ml = 64'(p) & mask;
        end else if ((y & mask) == 64'd0) begin
            mh  = x & mask;
            ml  = mask;
            mdz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            mh = r & mask;
            ml = q & mask;
        end
    endfunction

    // Called #1 after the edge that sampled start; follows the operation to done.
    task automatic wait_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit mid_start, input string tag);
        logic [63:0] eh, el;
        logic        edz;
        int          edges;
        int          busy_cnt;
        model(32, o, {32'd0, x}, {32'd0, y}, eh, el, edz);
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 100) begin
            if (busy) busy_cnt++;
            if (mid_start && edges == 5) begin
                start = 1'b1;
                op    = ~o;
                a     = ~x;
                b     = y ^ 32'h5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, edges, 33);
        chk({tag, ".busy_cycles"}, busy_cnt, 33);
        chk({tag, ".busy_fall"}, busy, 0);
        chk({tag, ".hi"}, hi, eh);
        chk({tag, ".lo"}, lo, el);
        chk({tag, ".dz"}, dz, edz);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit mid_start, input string tag);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(o, x, y, mid_start, tag);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h0000_0000 | $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   edges;
        bit   seen;
        logic [31:0] x, y;
        logic [1:0]  o;

        nrst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; abort = 1'b0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; abort8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.hi", hi, 0);
        chk("rst.lo", lo, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.dz", dz, 0);
        @(negedge clk);
        nrst = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        chk("multu_max.hi_k", hi, 32'hFFFF_FFFE);
        chk("multu_max.lo_k", lo, 32'h0000_0001);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);

        do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, "mult_neg");
        chk("mult_neg.hi_k", hi, 32'hFFFF_FFFF);
        chk("mult_neg.lo_k", lo, 32'hFFFF_FFF1);
        do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg");
        chk("div_neg.lo_k", lo, 32'hFFFF_FFFD);
        chk("div_neg.hi_k", hi, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h0000_0064, 32'h0000_0000, 1'b0, "divu_zero");
        chk("divu_zero.dz_k", dz, 1);
        chk("divu_zero.lo_k", lo, 32'hFFFF_FFFF);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        chk("div_ovf.lo_k", lo, 32'h8000_0000);
        chk("div_ovf.hi_k", hi, 32'h0000_0000);
        do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, "div_zero_neg");

        // Abort mid-RUN keeps the prior HI/LO and produces no done.
        do_op(2'b10, 32'd5, 32'd2, 1'b0, "setup_1_2");
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort.busy", busy, 0);
        seen = 1'b0;
        repeat (40) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort.no_done", seen, 0);
        chk("abort.hi", hi, 1);
        chk("abort.lo", lo, 2);

        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort.busy", busy, 0);
        @(posedge clk); #1;
        chk("start_abort.busy2", busy, 0);
        chk("start_abort.done", done, 0);

        do_op(2'b01, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, "mid_start");

        // A start presented in the done cycle is accepted.
        do_op(2'b00, 32'd7, 32'd9, 1'b0, "pre_b2b");
        start = 1'b1; op = 2'b11; a = 32'hFFFF_FF00; b = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.busy", busy, 1);
        chk("b2b.done_low", done, 0);
        wait_result(2'b11, 32'hFFFF_FF00, 32'd13, 1'b0, "b2b");

        for (int i = 0; i < 25; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            do_op(o, x, y, (i % 5) == 0, $sformatf("rnd%0d_op%0d", i, o));
        end

        // Reset mid-RUN clears everything, including a set dz.
        do_op(2'b10, 32'h0000_0064, 32'h0000_0000, 1'b0, "pre_rst");
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h55; b = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        @(posedge clk); #1;
        chk("midrst.hi", hi, 0);
        chk("midrst.lo", lo, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.dz", dz, 0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("midrst.no_done", seen, 0);

        @(negedge clk);
        start8 = 1'b1; op8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0;
        while (!done8 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("w8.latency", edges, 9);
        chk("w8.hi", hi8, 8'hFE);
        chk("w8.lo", lo8, 8'h01);
        chk("w8.dz", dz8, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
